// File: rtl/wb_muldiv_pkg.sv
// Shared constants and types for the write-back stage and its mul/div engine.
package wb_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = XLEN;
  localparam int unsigned CNT_W = $clog2(ITERS);

  localparam logic [5:0] OP_RFORM = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // Low two func bits of MULT/MULTU/DIV/DIVU select the engine operation.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
  endfunction

endpackage

// File: rtl/wb_muldiv_iter.sv
// Iterative 32-cycle multiply (shift-add) and divide (restoring) engine with sign fixup.
module wb_muldiv_iter
  import wb_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_hi_res_c,
  output logic [XLEN-1:0] o_lo_res_c
);

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_a_raw;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dbz;

  logic              w_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_sa     = w_signed & i_a[XLEN-1];
  assign w_sb     = w_signed & i_b[XLEN-1];
  assign w_abs_a  = w_sa ? XLEN'(-i_a) : i_a;
  assign w_abs_b  = w_sb ? XLEN'(-i_b) : i_b;

  // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : (XLEN+1)'(0));
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_acc_next = !r_is_div ? {w_mul_sum, r_acc[XLEN-1:1]} :
                      w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                                     {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_q = w_acc_next[XLEN-1:0];
  assign w_r = w_acc_next[2*XLEN-1:XLEN];

  assign o_busy   = (r_state == ST_BUSY);
  assign o_done_c = (r_state == ST_BUSY) && (r_cnt == CNT_W'(ITERS-1));

  // Final results from the last step; divide-by-zero bypasses the sign fixup.
  always_comb begin
    o_hi_res_c = '0;
    o_lo_res_c = '0;
    if (r_is_div) begin
      if (r_dbz) begin
        o_hi_res_c = r_a_raw;
        o_lo_res_c = '1;
      end else begin
        o_lo_res_c = r_neg_q ? XLEN'(-w_q) : w_q;
        o_hi_res_c = r_neg_r ? XLEN'(-w_r) : w_r;
      end
    end else begin
      {o_hi_res_c, o_lo_res_c} = r_neg_q ? (2*XLEN)'(-w_acc_next) : w_acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= ST_BUSY;
            r_cnt    <= '0;
            r_acc    <= {XLEN'(0), w_abs_a};
            r_b      <= w_abs_b;
            r_a_raw  <= i_a;
            r_is_div <= i_op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dbz    <= (i_b == '0);
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_W'(ITERS-1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_muldiv.sv
// Write-back stage: register write-data mux, HI/LO registers and mul/div stall control.
module wb_muldiv
  import wb_muldiv_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] Ins,
  input  logic            InsValid,
  input  logic [XLEN-1:0] Rdata1,
  input  logic [XLEN-1:0] Rdata2,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] MemRdata,
  input  logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] Wdata,
  output logic            Stall,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic [5:0]      w_op;
  logic [5:0]      w_func;
  logic            w_rform;
  logic            w_accept;
  logic            w_start;
  logic            w_busy;
  logic            w_done;
  logic [XLEN-1:0] w_hi_res;
  logic [XLEN-1:0] w_lo_res;
  logic            w_unused_ins;

  assign w_op         = Ins[31:26];
  assign w_func       = Ins[5:0];
  assign w_unused_ins = ^Ins[25:6];
  assign w_rform      = (w_op == OP_RFORM);
  assign w_accept     = InsValid & ~w_busy;
  assign w_start      = w_accept & w_rform & is_muldiv(w_func);

  assign Stall = w_busy;
  assign HI    = r_hi;
  assign LO    = r_lo;

  wb_muldiv_iter u_iter (
    .clk        (CLK),
    .rst_n      (RST),
    .i_start    (w_start),
    .i_op       (w_func[1:0]),
    .i_a        (Rdata1),
    .i_b        (Rdata2),
    .o_busy     (w_busy),
    .o_done_c   (w_done),
    .o_hi_res_c (w_hi_res),
    .o_lo_res_c (w_lo_res)
  );

  // Write-data select, not gated by Stall.
  always_comb begin
    Wdata = ALUResult;
    if (w_op == OP_LW) begin
      Wdata = MemRdata;
    end else if ((w_op == OP_JAL) || (w_rform && (w_func == F_JALR))) begin
      Wdata = PCPlus4;
    end else if (w_rform && (w_func == F_MFHI)) begin
      Wdata = r_hi;
    end else if (w_rform && (w_func == F_MFLO)) begin
      Wdata = r_lo;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (w_accept && w_rform && (w_func == F_MTHI)) begin
      r_hi <= Rdata1;
    end else if (w_accept && w_rform && (w_func == F_MTLO)) begin
      r_lo <= Rdata1;
    end
  end

endmodule

// File: tb/tb_wb_muldiv.sv
// Scoreboard bench for wb_muldiv: mux select, HI/LO moves, mul/div results, stall timing, reset.
module tb_wb_muldiv;
  import wb_muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Ins = '0;
  logic        InsValid = 1'b0;
  logic [31:0] Rdata1 = '0;
  logic [31:0] Rdata2 = '0;
  logic [31:0] ALUResult = 32'hA1A1_0001;
  logic [31:0] MemRdata = 32'hBEEF_0002;
  logic [31:0] PCPlus4 = 32'h0040_0104;
  logic [31:0] Wdata;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 CLK = ~CLK;

  wb_muldiv dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .InsValid(InsValid),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .ALUResult(ALUResult),
    .MemRdata(MemRdata), .PCPlus4(PCPlus4),
    .Wdata(Wdata), .Stall(Stall), .HI(HI), .LO(LO)
  );

  function automatic logic [31:0] rins(input logic [5:0] func);
    return {26'd0, func};
  endfunction

  // Reference {HI,LO} built from native wide arithmetic.
  function automatic logic [63:0] model(input logic [5:0] func, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (func)
      F_MULT:  r = 64'(sa * sb);
      F_MULTU: r = {32'd0, a} * {32'd0, b};
      F_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      F_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge CLK);
    while (Stall && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic run_op(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n;
    logic [63:0] exp;
    @(negedge CLK);
    Ins = rins(func); Rdata1 = a; Rdata2 = b; InsValid = 1'b1;
    sb_q.push_back(model(func, a, b));
    @(posedge CLK);
    #1 InsValid = 1'b0;
    wait_idle(n);
    exp = sb_q.pop_front();
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected 32", name, n);
    end
    checks++;
    if (HI !== exp[63:32]) begin
      errors++;
      $display("FAIL %s HI: got %h expected %h", name, HI, exp[63:32]);
    end
    checks++;
    if (LO !== exp[31:0]) begin
      errors++;
      $display("FAIL %s LO: got %h expected %h", name, LO, exp[31:0]);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (Stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b hi=%h lo=%h expected 0/0/0", Stall, HI, LO);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_spec_vectors();
    run_op(F_MULT, 32'hFFFF_FFFF, 32'd3, "mult_neg1x3");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL mult_const: got %h%h expected FFFFFFFFFFFFFFFD", HI, LO);
    end
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'd3, "multu");
    checks++;
    if ({HI, LO} !== 64'h0000_0002_FFFF_FFFD) begin
      errors++;
      $display("FAIL multu_const: got %h%h expected 00000002FFFFFFFD", HI, LO);
    end
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_const: got %h%h expected FFFFFFFFFFFFFFFD", HI, LO);
    end
    run_op(F_DIVU, 32'd100, 32'd0, "divu_by0");
    run_op(F_DIV, 32'hFFFF_FF9C, 32'd0, "div_neg_by0");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if ({HI, LO} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const: got %h%h expected 0000000080000000", HI, LO);
    end
    run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
  endtask

  task automatic test_random();
    logic [5:0] fn [4];
    fn[0] = F_MULT; fn[1] = F_MULTU; fn[2] = F_DIV; fn[3] = F_DIVU;
    for (int i = 0; i < 8; i++) begin
      run_op(fn[i % 4], $urandom, (i == 5) ? 32'd0 : $urandom_range(1, 32'hFFFF_FFFF), "rand");
    end
  endtask

  task automatic test_moves();
    @(negedge CLK);
    Ins = rins(F_MTHI); Rdata1 = 32'h0000_1234; InsValid = 1'b1;
    @(posedge CLK);
    #1 Ins = rins(F_MTLO); Rdata1 = 32'h0000_5678;
    checks++;
    if (HI !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi: got %h expected 00001234", HI);
    end
    @(posedge CLK);
    #1 InsValid = 1'b0; Ins = rins(F_MTHI); Rdata1 = 32'hDEAD_DEAD;
    checks++;
    if (LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL mtlo: got %h expected 00005678", LO);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (HI !== 32'h0000_1234) begin
      errors++;
      $display("FAIL bubble_mthi: got %h expected 00001234", HI);
    end
  endtask

  task automatic test_wdata_mux();
    logic [31:0] exp [6];
    logic [31:0] ins [6];
    ins[0] = {OP_LW, 20'd0, F_MFHI};  exp[0] = MemRdata;
    ins[1] = {OP_JAL, 26'h12345};     exp[1] = PCPlus4;
    ins[2] = rins(F_JALR);            exp[2] = PCPlus4;
    ins[3] = rins(F_MFHI);            exp[3] = 32'h0000_1234;
    ins[4] = rins(F_MFLO);            exp[4] = 32'h0000_5678;
    ins[5] = rins(6'h20);             exp[5] = ALUResult;
    InsValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      Ins = ins[i];
      #1;
      checks++;
      if (Wdata !== exp[i]) begin
        errors++;
        $display("FAIL wdata_mux[%0d]: got %h expected %h", i, Wdata, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] exp;
    @(negedge CLK);
    Ins = rins(F_MULT); Rdata1 = 32'd6; Rdata2 = 32'd7; InsValid = 1'b1;
    sb_q.push_back(model(F_MULT, 32'd6, 32'd7));
    @(posedge CLK);
    #1 Ins = rins(F_MFLO);
    wait_idle(n);
    exp = sb_q.pop_front();
    checks++;
    if (n !== 32 || Wdata !== exp[31:0]) begin
      errors++;
      $display("FAIL b2b_mflo: got stall=%0d wdata=%h expected 32/%h", n, Wdata, exp[31:0]);
    end
    Ins = rins(F_MTHI); Rdata1 = 32'h0000_ABCD;
    @(posedge CLK);
    #1 InsValid = 1'b0;
    checks++;
    if (HI !== 32'h0000_ABCD || LO !== 32'd42) begin
      errors++;
      $display("FAIL b2b_mthi: got hi=%h lo=%h expected 0000abcd/0000002a", HI, LO);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge CLK);
    Ins = rins(F_DIV); Rdata1 = 32'd1000; Rdata2 = 32'd7; InsValid = 1'b1;
    @(posedge CLK);
    #1 InsValid = 1'b0;
    repeat (10) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got stall=%b hi=%h lo=%h expected 0/0/0", Stall, HI, LO);
    end
    @(negedge CLK);
    RST = 1'b1;
    run_op(F_MULT, 32'd2, 32'd3, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_moves();
    test_wdata_mux();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
